// File: rtl/run_director_if.sv
// Connection bundle between the game top level and the run director.
// The game side is the master (strobes, buttons, collisions); the director is the slave.
interface run_director_if #(
    parameter int LANES   = 3,
    parameter int OFS_W   = 12,
    parameter int SCORE_W = 16,
    parameter int LIVES   = 3
);
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LIVES_W = $clog2(LIVES + 1);

    logic               frame_tick;
    logic               btn_left;
    logic               btn_right;
    logic               coin_hit;
    logic               obstacle_hit;

    logic [2:0]         state_o;
    logic [OFS_W-1:0]   logo_voffset;
    logic [OFS_W-1:0]   player_voffset;
    logic [OFS_W-1:0]   player_hoffset;
    logic [LANE_W-1:0]  lane;
    logic               spawn_en;
    logic               invuln;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic               game_over;

    modport master (
        output frame_tick, btn_left, btn_right, coin_hit, obstacle_hit,
        input  state_o, logo_voffset, player_voffset, player_hoffset, lane,
               spawn_en, invuln, score, lives, game_over
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, coin_hit, obstacle_hit,
        output state_o, logo_voffset, player_voffset, player_hoffset, lane,
               spawn_en, invuln, score, lives, game_over
    );
endinterface

// File: rtl/run_director.sv
// Frame-paced sequencer for the runner game: intro animation, lane control, score,
// lives and game-over/restart, all advancing only on the frame_tick strobe.
module run_director #(
    parameter int LANES         = 3,
    parameter int LANE_PITCH    = 100,
    parameter int OFS_W         = 12,
    parameter int COUNTDOWN     = 5,
    parameter int LOGO_STEP     = 30,
    parameter int LOGO_END      = 640,
    parameter int PLAYER_START  = 180,
    parameter int PLAYER_STEP   = 20,
    parameter int PLAYER_END    = 50,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int SCORE_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    run_director_if.slave bus
);
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int CD_W    = (COUNTDOWN > 0) ? $clog2(COUNTDOWN + 1) : 1;
    localparam int IMM_W   = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam int CENTER  = (LANES - 1) / 2;

    localparam logic [OFS_W-1:0]   LOGO_STEP_V    = OFS_W'(LOGO_STEP);
    localparam logic [OFS_W-1:0]   LOGO_END_V     = OFS_W'(LOGO_END);
    localparam logic [OFS_W-1:0]   PLAYER_START_V = OFS_W'(PLAYER_START);
    localparam logic [OFS_W-1:0]   PLAYER_STEP_V  = OFS_W'(PLAYER_STEP);
    localparam logic [OFS_W-1:0]   PLAYER_END_V   = OFS_W'(PLAYER_END);
    localparam logic [LANE_W-1:0]  LANE_CENTER_V  = LANE_W'(CENTER);
    localparam logic [LANE_W-1:0]  LANE_MAX_V     = LANE_W'(LANES - 1);
    localparam logic [LIVES_W-1:0] LIVES_V        = LIVES_W'(LIVES);
    localparam logic [CD_W-1:0]    COUNTDOWN_V    = CD_W'(COUNTDOWN);
    localparam logic [IMM_W-1:0]   INVULN_V       = IMM_W'(INVULN_FRAMES);

    if (LOGO_END + LOGO_STEP >= 2 ** OFS_W) begin : g_bad_logo
        $error("run_director: LOGO_END + LOGO_STEP does not fit in OFS_W bits");
    end
    if (PLAYER_START >= 2 ** OFS_W) begin : g_bad_player
        $error("run_director: PLAYER_START does not fit in OFS_W bits");
    end
    if (LANES < 2 || LIVES < 1) begin : g_bad_counts
        $error("run_director: need LANES >= 2 and LIVES >= 1");
    end

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_LOGO_OUT  = 3'd2,
        S_PLAYER_IN = 3'd3,
        S_PLAY      = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic [OFS_W-1:0]   logo_q, logo_d;
    logic [OFS_W-1:0]   player_q, player_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic               pend_l_q, pend_r_q, pend_c_q, pend_o_q;
    logic               pend_l_d, pend_r_d, pend_c_d, pend_o_d;
    logic               btn_l_prev_q, btn_r_prev_q;
    logic               take_l, take_r, take_c, take_o;

    // An event arriving in the tick cycle itself is folded into that tick rather than lost.
    assign take_l = pend_l_q | (bus.btn_left  & ~btn_l_prev_q);
    assign take_r = pend_r_q | (bus.btn_right & ~btn_r_prev_q);
    assign take_c = pend_c_q | bus.coin_hit;
    assign take_o = pend_o_q | bus.obstacle_hit;

    always_ff @(posedge clk) begin
        btn_l_prev_q <= bus.btn_left;
        btn_r_prev_q <= bus.btn_right;
        if (rst) begin
            state_q  <= S_INIT;
            cd_q     <= COUNTDOWN_V;
            logo_q   <= '0;
            player_q <= PLAYER_START_V;
            lane_q   <= LANE_CENTER_V;
            score_q  <= '0;
            lives_q  <= LIVES_V;
            imm_q    <= '0;
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            pend_c_q <= 1'b0;
            pend_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            logo_q   <= logo_d;
            player_q <= player_d;
            lane_q   <= lane_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            imm_q    <= imm_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            pend_c_q <= pend_c_d;
            pend_o_q <= pend_o_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        logo_d   = logo_q;
        player_d = player_q;
        lane_d   = lane_q;
        score_d  = score_q;
        lives_d  = lives_q;
        imm_d    = imm_q;
        pend_l_d = take_l;
        pend_r_d = take_r;
        pend_c_d = take_c;
        pend_o_d = take_o;

        if (bus.frame_tick) begin
            // Every tick consumes the pending flags, whether or not the state acts on them.
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
            pend_c_d = 1'b0;
            pend_o_d = 1'b0;
            case (state_q)
                S_INIT: state_d = S_COUNTDOWN;
                S_COUNTDOWN: begin
                    if (cd_q != '0) cd_d = cd_q - CD_W'(1);
                    else            state_d = S_LOGO_OUT;
                end
                S_LOGO_OUT: begin
                    if (logo_q < LOGO_END_V) logo_d = logo_q + LOGO_STEP_V;
                    else                     state_d = S_PLAYER_IN;
                end
                S_PLAYER_IN: begin
                    if (player_q > PLAYER_END_V) player_d = player_q - PLAYER_STEP_V;
                    else                         state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (take_l && !take_r && lane_q != '0)
                        lane_d = lane_q - LANE_W'(1);
                    else if (take_r && !take_l && lane_q != LANE_MAX_V)
                        lane_d = lane_q + LANE_W'(1);
                    if (take_c && score_q != '1)
                        score_d = score_q + SCORE_W'(1);
                    // A hit during immunity is dropped and the immunity keeps counting down.
                    if (take_o && imm_q == '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                        if (lives_q == LIVES_W'(1)) state_d = S_GAME_OVER;
                        else                        imm_d = INVULN_V;
                    end else if (imm_q != '0) begin
                        imm_d = imm_q - IMM_W'(1);
                    end
                end
                S_GAME_OVER: begin
                    if (take_l || take_r) begin
                        state_d  = S_INIT;
                        cd_d     = COUNTDOWN_V;
                        logo_d   = '0;
                        player_d = PLAYER_START_V;
                        lane_d   = LANE_CENTER_V;
                        score_d  = '0;
                        lives_d  = LIVES_V;
                        imm_d    = '0;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    assign bus.state_o        = state_q;
    assign bus.logo_voffset   = logo_q;
    assign bus.player_voffset = player_q;
    assign bus.player_hoffset = OFS_W'((int'(lane_q) - CENTER) * LANE_PITCH);
    assign bus.lane           = lane_q;
    assign bus.spawn_en       = (state_q == S_PLAY);
    assign bus.invuln         = (imm_q != '0);
    assign bus.score          = score_q;
    assign bus.lives          = lives_q;
    assign bus.game_over      = (state_q == S_GAME_OVER);
endmodule

// File: tb/tb_run_director.sv
// Bench for run_director: integer-level game model compared every cycle, plus literal checkpoints.
// A second instance with a 2-bit score shares the stimulus to exercise score saturation.
module tb_run_director;
    localparam int LANES         = 3;
    localparam int LANE_PITCH    = 100;
    localparam int COUNTDOWN     = 5;
    localparam int LOGO_STEP     = 30;
    localparam int LOGO_END      = 640;
    localparam int PLAYER_START  = 180;
    localparam int PLAYER_STEP   = 20;
    localparam int PLAYER_END    = 50;
    localparam int LIVES         = 3;
    localparam int INVULN_FRAMES = 60;
    localparam int CENTER        = (LANES - 1) / 2;
    localparam int SCORE_MAX     = 65535;
    localparam int SCORE2_MAX    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_tick = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic coin_hit = 1'b0;
    logic obstacle_hit = 1'b0;
    logic held_l = 1'b0;
    logic held_r = 1'b0;
    bit   checking = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    run_director_if #(.SCORE_W(16)) bus ();
    run_director_if #(.SCORE_W(2))  bus2 ();

    assign bus.frame_tick    = frame_tick;
    assign bus.btn_left      = btn_left;
    assign bus.btn_right     = btn_right;
    assign bus.coin_hit      = coin_hit;
    assign bus.obstacle_hit  = obstacle_hit;
    assign bus2.frame_tick   = frame_tick;
    assign bus2.btn_left     = btn_left;
    assign bus2.btn_right    = btn_right;
    assign bus2.coin_hit     = coin_hit;
    assign bus2.obstacle_hit = obstacle_hit;

    run_director #(.SCORE_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    run_director #(.SCORE_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Game model: plain integers, one step of the game rules per frame tick.
    int m_state, m_cd, m_logo, m_player, m_lane, m_score, m_score2, m_lives, m_imm;
    bit m_pl, m_pr, m_pc, m_po, m_prev_l, m_prev_r;

    function automatic void model_reset();
        m_state = 0; m_cd = COUNTDOWN; m_logo = 0; m_player = PLAYER_START;
        m_lane = CENTER; m_score = 0; m_score2 = 0; m_lives = LIVES; m_imm = 0;
        m_pl = 0; m_pr = 0; m_pc = 0; m_po = 0;
    endfunction

    function automatic void model_tick(bit l, bit r, bit c, bit o);
        case (m_state)
            0: m_state = 1;
            1: if (m_cd > 0) m_cd--; else m_state = 2;
            2: if (m_logo < LOGO_END) m_logo += LOGO_STEP; else m_state = 3;
            3: if (m_player > PLAYER_END) m_player -= PLAYER_STEP; else m_state = 4;
            4: begin
                if (l && !r) m_lane = (m_lane > 0) ? m_lane - 1 : 0;
                if (r && !l) m_lane = (m_lane < LANES - 1) ? m_lane + 1 : LANES - 1;
                if (c) begin
                    m_score  = (m_score  < SCORE_MAX)  ? m_score + 1  : SCORE_MAX;
                    m_score2 = (m_score2 < SCORE2_MAX) ? m_score2 + 1 : SCORE2_MAX;
                end
                if (o && m_imm == 0) begin
                    m_lives--;
                    if (m_lives == 0) m_state = 5;
                    else m_imm = INVULN_FRAMES;
                end else if (m_imm > 0) begin
                    m_imm--;
                end
            end
            5: if (l || r) model_reset();
            default: m_state = 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit el, er, ec, eo;
        el = m_pl | (btn_left & !m_prev_l);
        er = m_pr | (btn_right & !m_prev_r);
        ec = m_pc | coin_hit;
        eo = m_po | obstacle_hit;
        m_prev_l = btn_left;
        m_prev_r = btn_right;
        if (rst) begin
            model_reset();
        end else if (frame_tick) begin
            m_pl = 0; m_pr = 0; m_pc = 0; m_po = 0;
            model_tick(el, er, ec, eo);
        end else begin
            m_pl = el; m_pr = er; m_pc = ec; m_po = eo;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("state_o", int'(bus.state_o), m_state);
            checkOutput("logo_voffset", int'(bus.logo_voffset), m_logo);
            checkOutput("player_voffset", int'(bus.player_voffset), m_player);
            checkOutput("player_hoffset", int'($signed(bus.player_hoffset)), (m_lane - CENTER) * LANE_PITCH);
            checkOutput("lane", int'(bus.lane), m_lane);
            checkOutput("spawn_en", int'(bus.spawn_en), int'(m_state == 4));
            checkOutput("invuln", int'(bus.invuln), int'(m_imm != 0));
            checkOutput("score", int'(bus.score), m_score);
            checkOutput("lives", int'(bus.lives), m_lives);
            checkOutput("game_over", int'(bus.game_over), int'(m_state == 5));
            checkOutput("s2_state_o", int'(bus2.state_o), m_state);
            checkOutput("s2_logo", int'(bus2.logo_voffset), m_logo);
            checkOutput("s2_player", int'(bus2.player_voffset), m_player);
            checkOutput("s2_hoffset", int'($signed(bus2.player_hoffset)), (m_lane - CENTER) * LANE_PITCH);
            checkOutput("s2_lane", int'(bus2.lane), m_lane);
            checkOutput("s2_spawn_en", int'(bus2.spawn_en), int'(m_state == 4));
            checkOutput("s2_invuln", int'(bus2.invuln), int'(m_imm != 0));
            checkOutput("s2_score", int'(bus2.score), m_score2);
            checkOutput("s2_lives", int'(bus2.lives), m_lives);
            checkOutput("s2_game_over", int'(bus2.game_over), int'(m_state == 5));
        end
    end

    // One frame of four clocks: tick first, then any requested events one cycle later.
    task automatic applyStimulus(input bit l, input bit r, input bit c, input bit o);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick   = 1'b0;
        btn_left     = l | held_l;
        btn_right    = r | held_r;
        coin_hit     = c;
        obstacle_hit = o;
        @(negedge clk);
        btn_left     = held_l;
        btn_right    = held_r;
        coin_hit     = 1'b0;
        obstacle_hit = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, int'(bus.state_o), 0);
        checkOutput({tag, "_logo"}, int'(bus.logo_voffset), 0);
        checkOutput({tag, "_player"}, int'(bus.player_voffset), 180);
        checkOutput({tag, "_lane"}, int'(bus.lane), 1);
        checkOutput({tag, "_score"}, int'(bus.score), 0);
        checkOutput({tag, "_lives"}, int'(bus.lives), 3);
        checkOutput({tag, "_spawn"}, int'(bus.spawn_en), 0);
        checkOutput({tag, "_go"}, int'(bus.game_over), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        pulseReset();
        checking = 1'b1;
        checkResetValues("por");

        // Intro sequence reaches PLAY on the 38th tick.
        repeat (37) applyStimulus(0, 0, 0, 0);
        checkOutput("intro_t37_state", int'(bus.state_o), 3);
        checkOutput("intro_t37_spawn", int'(bus.spawn_en), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("intro_t38_state", int'(bus.state_o), 4);
        checkOutput("intro_logo", int'(bus.logo_voffset), 660);
        checkOutput("intro_player", int'(bus.player_voffset), 40);
        checkOutput("intro_spawn", int'(bus.spawn_en), 1);

        // Lane moves right then left, with saturation at both ends.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("right1_lane", int'(bus.lane), 2);
        applyStimulus(0, 1, 0, 0);
        checkOutput("right2_lane", int'(bus.lane), 2);
        applyStimulus(0, 0, 0, 0);
        checkOutput("right3_lane", int'(bus.lane), 2);
        checkOutput("right_hoffset", int'($signed(bus.player_hoffset)), 100);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("left1_lane", int'(bus.lane), 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("left2_lane", int'(bus.lane), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("left3_lane", int'(bus.lane), 0);
        checkOutput("left_hoffset", int'($signed(bus.player_hoffset)), -100);

        // Simultaneous presses cancel; a held button moves only once.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre_both_lane", int'(bus.lane), 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("both_lane", int'(bus.lane), 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        held_r = 1'b1;
        repeat (10) applyStimulus(0, 0, 0, 0);
        held_r = 1'b0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("held_lane", int'(bus.lane), 1);

        // Coins: three, then two more to saturate the 2-bit instance.
        repeat (3) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("coin3_score", int'(bus.score), 3);
        repeat (2) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("coin5_score", int'(bus.score), 5);
        checkOutput("coin5_score_sat", int'(bus2.score), 3);

        // First hit, a second one 30 ticks later lands inside the immunity window.
        applyStimulus(0, 0, 0, 1);
        for (int i = 1; i <= 60; i++) applyStimulus(0, 0, 0, i == 30);
        checkOutput("hit1_lives", int'(bus.lives), 2);
        checkOutput("hit1_invuln_t59", int'(bus.invuln), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("hit1_invuln_t60", int'(bus.invuln), 0);

        // Two more spaced hits end the game; then a button restarts it.
        applyStimulus(0, 0, 0, 1);
        repeat (61) applyStimulus(0, 0, 0, 0);
        checkOutput("hit2_lives", int'(bus.lives), 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("over_lives", int'(bus.lives), 0);
        checkOutput("over_state", int'(bus.state_o), 5);
        checkOutput("over_flag", int'(bus.game_over), 1);
        checkOutput("over_spawn", int'(bus.spawn_en), 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("over_frozen_score", int'(bus.score), 5);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkResetValues("restart");

        // Reset in the middle of the logo slide.
        repeat (15) applyStimulus(0, 0, 0, 0);
        checkOutput("mid_logo_state", int'(bus.state_o), 2);
        checkOutput("mid_logo_offset", int'(bus.logo_voffset), 240);
        pulseReset();
        checkResetValues("rst_logo");

        // Reset in PLAY with a score of seven.
        repeat (38) applyStimulus(0, 0, 0, 0);
        repeat (7) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("play_score7", int'(bus.score), 7);
        checkOutput("play_score7_sat", int'(bus2.score), 3);
        pulseReset();
        checkResetValues("rst_play");
        repeat (3) applyStimulus(0, 0, 0, 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
